// File: rtl/stage_wb_trap_pkg.sv
// stage_wb_trap_pkg: shared encodings for the write-back / trap stage.
// Holds the RV32 opcodes, the funct3 encodings for loads and CSR ops,
// the machine CSR addresses, the mcause codes, the fixed SYSTEM encodings,
// the FSM state encoding and the load-extension helper.
package stage_wb_trap_pkg;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Load funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // CSR funct3; bit 2 selects the immediate form, bits 1:0 the operation
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;
    localparam logic [1:0] CSR_OP_RW = 2'b01;
    localparam logic [1:0] CSR_OP_RS = 2'b10;
    localparam logic [1:0] CSR_OP_RC = 2'b11;

    // Machine CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MHARTID = 12'hF14;

    // mcause codes
    localparam logic [31:0] CAUSE_INST_MIS = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
    localparam logic [31:0] CAUSE_BREAK    = 32'd3;
    localparam logic [31:0] CAUSE_LD_MIS   = 32'd4;
    localparam logic [31:0] CAUSE_ST_MIS   = 32'd6;
    localparam logic [31:0] CAUSE_ECALL_M  = 32'd11;

    // Fixed SYSTEM encodings
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    // FSM states
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Pick the byte/half addressed by offset out of an aligned word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  offset,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LBU:  return {24'b0, b};
            F3_LHU:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/wb_trap_csr.sv
// wb_trap_csr: machine trap CSR file (mstatus, mtvec, mepc, mcause, mtval,
// mhartid) for the write-back / trap stage.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   csr_addr_i          CSR address of the current instruction
//   csr_we_i            commit a CSR write this edge
//   csr_op_i            RW / RS / RC
//   csr_operand_i       rs1 value or zero-extended zimm
//   csr_rdata_o         current (old) value of the addressed CSR
//   csr_known_o         address is implemented
//   csr_ro_o            address is read-only
//   trap_i, trap_*_i    record a trap (epc, cause, tval) and stack MIE
//   mret_i              restore MIE from MPIE
//   mtvec_o, mepc_o     redirect targets
module wb_trap_csr
    import stage_wb_trap_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter bit          HAS_C       = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] csr_addr_i,
    input  logic        csr_we_i,
    input  logic [1:0]  csr_op_i,
    input  logic [31:0] csr_operand_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_known_o,
    output logic        csr_ro_o,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_epc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);

    localparam logic [31:0] EPC_MASK  = HAS_C ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
    localparam logic [31:0] TVEC_MASK = 32'hFFFF_FFFC;

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
    logic [31:0] wval;

    // Read mux; MPP is hard-wired to machine mode.
    always_comb begin
        csr_rdata_o = 32'b0;
        csr_known_o = 1'b1;
        csr_ro_o    = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS: csr_rdata_o = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            CSR_MTVEC:   csr_rdata_o = mtvec_q;
            CSR_MEPC:    csr_rdata_o = mepc_q;
            CSR_MCAUSE:  csr_rdata_o = mcause_q;
            CSR_MTVAL:   csr_rdata_o = mtval_q;
            CSR_MHARTID: csr_ro_o    = 1'b1;
            default:     csr_known_o = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op_i)
            CSR_OP_RW: wval = csr_operand_i;
            CSR_OP_RS: wval = csr_rdata_o | csr_operand_i;
            CSR_OP_RC: wval = csr_rdata_o & ~csr_operand_i;
            default:   wval = csr_rdata_o;
        endcase
    end

    // A trap outranks MRET, which outranks an explicit CSR write.
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        if (trap_i) begin
            mepc_d   = trap_epc_i & EPC_MASK;
            mcause_d = trap_cause_i;
            mtval_d  = trap_tval_i;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_we_i) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mie_d  = wval[3];
                    mpie_d = wval[7];
                end
                CSR_MTVEC:  mtvec_d  = wval & TVEC_MASK;
                CSR_MEPC:   mepc_d   = wval & EPC_MASK;
                CSR_MCAUSE: mcause_d = wval;
                CSR_MTVAL:  mtval_d  = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= MTVEC_RESET & TVEC_MASK;
            mepc_q   <= 32'b0;
            mcause_q <= 32'b0;
            mtval_q  <= 32'b0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
        end
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;

endmodule

// File: rtl/stage_wb_trap.sv
// stage_wb_trap: final RV32 pipeline stage. Writes the register file,
// takes prioritised synchronous exceptions, executes MRET, and drives the
// PC redirect plus a FLUSH_CYCLES-long flush of the younger stages.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   valid_i / ready_o             retiring-instruction handshake
//   pc_i, instruction_i           instruction being retired
//   alu_d_i, mem_d_i, mem_addr_i  ALU result, raw load word, effective address
//   csr_wdata_i                   rs1 value or zimm for CSR instructions
//   e_*_i                         upstream exception flags
//   rd_o, rf_wd_o, we_rf_o        register-file write port (registered)
//   redirect_o, redirect_pc_o     one-cycle PC redirect
//   flush_o                       flush younger stages
//   is_exc_taken_o, retire_o      trap / commit pulses
//   dbg_state_o                   current FSM state
//
// Handshake: an instruction transfers on a rising edge where valid_i and
// ready_o are both high; ready_o is high exactly when the FSM is in RUN and
// does not depend on valid_i. valid_i is ignored whenever ready_o is low.
module stage_wb_trap
    import stage_wb_trap_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter bit          HAS_C        = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] instruction_i,
    input  logic [31:0] alu_d_i,
    input  logic [31:0] mem_d_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        e_illegal_inst_i,
    input  logic        e_inst_addr_mis_i,
    input  logic        e_ld_addr_mis_i,
    input  logic        e_st_addr_mis_i,
    output logic [4:0]  rd_o,
    output logic [31:0] rf_wd_o,
    output logic        we_rf_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        is_exc_taken_o,
    output logic        retire_o,
    output logic [0:0]  dbg_state_o
);

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1;
    logic        accept, is_csr, is_mret, csr_wr_req, csr_illegal, writes_rd;
    logic        exc_any;
    logic [31:0] exc_cause, exc_tval, wb_data;
    logic [31:0] csr_rdata, mtvec, mepc;
    logic        csr_known, csr_ro;

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rf_wd_q, rf_wd_d, redirect_pc_q, redirect_pc_d;
    logic        we_rf_q, we_rf_d, redirect_q, redirect_d;
    logic        exc_q, exc_d, retire_q, retire_d;

    assign opcode = instruction_i[6:0];
    assign rd     = instruction_i[11:7];
    assign funct3 = instruction_i[14:12];
    assign rs1    = instruction_i[19:15];

    assign ready_o = (state_q == ST_RUN);
    assign accept  = valid_i & ready_o;

    assign is_csr  = (opcode == OPC_SYSTEM) && (funct3[1:0] != 2'b00);
    assign is_mret = (instruction_i == INST_MRET);
    // Set/clear with a zero source field is a pure read, so it may target mhartid.
    assign csr_wr_req  = is_csr && ((funct3[1:0] == CSR_OP_RW) || (rs1 != 5'd0));
    assign csr_illegal = is_csr && (!csr_known || (csr_wr_req && csr_ro));

    always_comb begin
        exc_any   = 1'b1;
        exc_cause = 32'b0;
        exc_tval  = 32'b0;
        if (e_inst_addr_mis_i) begin
            exc_cause = CAUSE_INST_MIS;
            exc_tval  = alu_d_i;
        end else if (e_illegal_inst_i || csr_illegal) begin
            exc_cause = CAUSE_ILLEGAL;
            exc_tval  = instruction_i;
        end else if (instruction_i == INST_EBREAK) begin
            exc_cause = CAUSE_BREAK;
            exc_tval  = pc_i;
        end else if (instruction_i == INST_ECALL) begin
            exc_cause = CAUSE_ECALL_M;
        end else if (e_ld_addr_mis_i) begin
            exc_cause = CAUSE_LD_MIS;
            exc_tval  = mem_addr_i;
        end else if (e_st_addr_mis_i) begin
            exc_cause = CAUSE_ST_MIS;
            exc_tval  = mem_addr_i;
        end else begin
            exc_any = 1'b0;
        end
    end

    always_comb begin
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD: writes_rd = 1'b1;
            OPC_SYSTEM:                  writes_rd = is_csr;
            default:                     writes_rd = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OPC_LOAD:   wb_data = load_extend(funct3, mem_addr_i[1:0], mem_d_i);
            OPC_SYSTEM: wb_data = csr_rdata;
            default:    wb_data = alu_d_i;
        endcase
    end

    wb_trap_csr #(
        .MTVEC_RESET (MTVEC_RESET),
        .HAS_C       (HAS_C)
    ) u_csr (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .csr_addr_i    (instruction_i[31:20]),
        .csr_we_i      (accept & ~exc_any & csr_wr_req),
        .csr_op_i      (funct3[1:0]),
        .csr_operand_i (csr_wdata_i),
        .csr_rdata_o   (csr_rdata),
        .csr_known_o   (csr_known),
        .csr_ro_o      (csr_ro),
        .trap_i        (accept & exc_any),
        .trap_cause_i  (exc_cause),
        .trap_epc_i    (pc_i),
        .trap_tval_i   (exc_tval),
        .mret_i        (accept & ~exc_any & is_mret),
        .mtvec_o       (mtvec),
        .mepc_o        (mepc)
    );

    // Output pulses are rebuilt every cycle; they only carry data after an accept.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_d          = 5'b0;
        rf_wd_d       = 32'b0;
        we_rf_d       = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = 32'b0;
        exc_d         = 1'b0;
        retire_d      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    rd_d     = rd;
                    rf_wd_d  = wb_data;
                    we_rf_d  = ~exc_any & writes_rd & (rd != 5'd0);
                    retire_d = ~exc_any;
                    if (exc_any || is_mret) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = exc_any ? mtvec : mepc;
                        exc_d         = exc_any;
                        state_d       = ST_FLUSH;
                        cnt_d         = FLUSH_LAST;
                    end
                end
            end
            default: begin
                // The first FLUSH cycle coincides with the redirect pulse.
                if (cnt_q == 4'd0) state_d = ST_RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_RUN;
            cnt_q         <= 4'd0;
            rd_q          <= 5'd0;
            rf_wd_q       <= 32'd0;
            we_rf_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            exc_q         <= 1'b0;
            retire_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            rf_wd_q       <= rf_wd_d;
            we_rf_q       <= we_rf_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            exc_q         <= exc_d;
            retire_q      <= retire_d;
        end
    end

    assign rd_o           = rd_q;
    assign rf_wd_o        = rf_wd_q;
    assign we_rf_o        = we_rf_q;
    assign redirect_o     = redirect_q;
    assign redirect_pc_o  = redirect_pc_q;
    assign flush_o        = (state_q == ST_FLUSH);
    assign is_exc_taken_o = exc_q;
    assign retire_o       = retire_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_stage_wb_trap.sv
// tb_stage_wb_trap: directed bench for stage_wb_trap with hand-computed
// expected values; inputs change on the falling edge, outputs are sampled
// on the falling edge after the accepting rising edge.
module tb_stage_wb_trap;
    import stage_wb_trap_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, valid_i;
    logic        ready_o;
    logic [31:0] pc_i, instruction_i, alu_d_i, mem_d_i, mem_addr_i, csr_wdata_i;
    logic        e_illegal_inst_i, e_inst_addr_mis_i, e_ld_addr_mis_i, e_st_addr_mis_i;
    logic [4:0]  rd_o;
    logic [31:0] rf_wd_o, redirect_pc_o;
    logic        we_rf_o, redirect_o, flush_o, is_exc_taken_o, retire_o;
    logic [0:0]  dbg_state_o;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [3:0] NO_EXC  = 4'b0000;
    // flag vector order: {inst_mis, illegal, ld_mis, st_mis}
    localparam logic [3:0] F_INST  = 4'b1000;
    localparam logic [3:0] F_ILL   = 4'b0100;
    localparam logic [3:0] F_LD    = 4'b0010;
    localparam logic [3:0] F_ST    = 4'b0001;

    stage_wb_trap #(
        .MTVEC_RESET  (32'h0000_0100),
        .FLUSH_CYCLES (2),
        .HAS_C        (1'b0)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .pc_i              (pc_i),
        .instruction_i     (instruction_i),
        .alu_d_i           (alu_d_i),
        .mem_d_i           (mem_d_i),
        .mem_addr_i        (mem_addr_i),
        .csr_wdata_i       (csr_wdata_i),
        .e_illegal_inst_i  (e_illegal_inst_i),
        .e_inst_addr_mis_i (e_inst_addr_mis_i),
        .e_ld_addr_mis_i   (e_ld_addr_mis_i),
        .e_st_addr_mis_i   (e_st_addr_mis_i),
        .rd_o              (rd_o),
        .rf_wd_o           (rf_wd_o),
        .we_rf_o           (we_rf_o),
        .redirect_o        (redirect_o),
        .redirect_pc_o     (redirect_pc_o),
        .flush_o           (flush_o),
        .is_exc_taken_o    (is_exc_taken_o),
        .retire_o          (retire_o),
        .dbg_state_o       (dbg_state_o)
    );

    // Clock / global time limit
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] op_inst(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [4:0] rd);
        return {7'b0, 5'd2, 5'd1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] csr_inst(input logic [11:0] csr, input logic [4:0] rs1,
                                             input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1, f3, rd, OPC_SYSTEM};
    endfunction

    // Bounded wait for RUN; an expired bound is reported as a failed check.
    task automatic wait_ready();
        int n = 0;
        while (ready_o !== 1'b1 && n < 32) begin
            @(negedge clk_i);
            n++;
        end
        if (ready_o !== 1'b1) check("wait_ready_timeout", {31'b0, ready_o}, 32'd1);
    endtask

    // Present one instruction; returns on the falling edge after it is accepted.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] flags);
        wait_ready();
        instruction_i = instr;
        pc_i          = pc;
        alu_d_i       = alu;
        mem_d_i       = mem;
        mem_addr_i    = addr;
        csr_wdata_i   = wdata;
        {e_inst_addr_mis_i, e_illegal_inst_i, e_ld_addr_mis_i, e_st_addr_mis_i} = flags;
        valid_i       = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        {e_inst_addr_mis_i, e_illegal_inst_i, e_ld_addr_mis_i, e_st_addr_mis_i} = NO_EXC;
    endtask

    // Read a CSR into x31 through CSRRS with rs1=x0 and compare the write-back data.
    task automatic read_csr(input string tag, input logic [11:0] csr, input logic [31:0] exp);
        send(csr_inst(csr, 5'd0, F3_CSRRS, 5'd31), 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, NO_EXC);
        check(tag, rf_wd_o, exp);
    endtask

    task automatic check_trap(input string tag, input logic [31:0] target);
        check({tag, "_exc"},      {31'b0, is_exc_taken_o}, 32'd1);
        check({tag, "_redirect"}, {31'b0, redirect_o}, 32'd1);
        check({tag, "_pc"},       redirect_pc_o, target);
        check({tag, "_we"},       {31'b0, we_rf_o}, 32'd0);
        check({tag, "_retire"},   {31'b0, retire_o}, 32'd0);
    endtask

    logic [31:0] instr;

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        {pc_i, instruction_i, alu_d_i, mem_d_i, mem_addr_i, csr_wdata_i} = '0;
        {e_inst_addr_mis_i, e_illegal_inst_i, e_ld_addr_mis_i, e_st_addr_mis_i} = NO_EXC;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Reset state
        check("rst_ready",    {31'b0, ready_o}, 32'd1);
        check("rst_flush",    {31'b0, flush_o}, 32'd0);
        check("rst_we",       {31'b0, we_rf_o}, 32'd0);
        check("rst_redirect", {31'b0, redirect_o}, 32'd0);
        check("rst_rpc",      redirect_pc_o, 32'd0);
        check("rst_exc",      {31'b0, is_exc_taken_o}, 32'd0);
        check("rst_retire",   {31'b0, retire_o}, 32'd0);
        check("rst_rd",       {27'b0, rd_o}, 32'd0);
        check("rst_state",    {31'b0, dbg_state_o}, {31'b0, ST_RUN});

        // ALU write-back
        send(op_inst(OPC_OP, 3'b000, 5'd5), 32'h10, 32'h1234, 32'h0, 32'h0, 32'h0, NO_EXC);
        check("add_we",     {31'b0, we_rf_o}, 32'd1);
        check("add_rd",     {27'b0, rd_o}, 32'd5);
        check("add_wd",     rf_wd_o, 32'h1234);
        check("add_retire", {31'b0, retire_o}, 32'd1);
        check("add_redir",  {31'b0, redirect_o}, 32'd0);
        @(negedge clk_i);
        check("idle_we",     {31'b0, we_rf_o}, 32'd0);
        check("idle_retire", {31'b0, retire_o}, 32'd0);

        send(op_inst(OPC_OP, 3'b000, 5'd0), 32'h14, 32'h1234, 32'h0, 32'h0, 32'h0, NO_EXC);
        check("add_x0_we",     {31'b0, we_rf_o}, 32'd0);
        check("add_x0_retire", {31'b0, retire_o}, 32'd1);

        // Load extension, word 0x80FF7F00
        send(op_inst(OPC_LOAD, F3_LB, 5'd6), 32'h18, 32'h0, 32'h80FF_7F00, 32'h1003, 32'h0, NO_EXC);
        check("lb_wd", rf_wd_o, 32'hFFFF_FF80);
        check("lb_we", {31'b0, we_rf_o}, 32'd1);
        send(op_inst(OPC_LOAD, F3_LHU, 5'd7), 32'h1C, 32'h0, 32'h80FF_7F00, 32'h1002, 32'h0, NO_EXC);
        check("lhu_wd", rf_wd_o, 32'h0000_80FF);
        send(op_inst(OPC_LOAD, F3_LH, 5'd7), 32'h20, 32'h0, 32'h80FF_7F00, 32'h1002, 32'h0, NO_EXC);
        check("lh_wd", rf_wd_o, 32'hFFFF_80FF);
        send(op_inst(OPC_LOAD, F3_LBU, 5'd7), 32'h24, 32'h0, 32'h80FF_7F00, 32'h1001, 32'h0, NO_EXC);
        check("lbu_wd", rf_wd_o, 32'h0000_007F);
        send(op_inst(OPC_LOAD, F3_LW, 5'd7), 32'h28, 32'h0, 32'h80FF_7F00, 32'h1000, 32'h0, NO_EXC);
        check("lw_wd", rf_wd_o, 32'h80FF_7F00);

        // Store: retires without a register write
        send(op_inst(OPC_STORE, 3'b010, 5'd3), 32'h2C, 32'h0, 32'h0, 32'h1000, 32'h0, NO_EXC);
        check("sw_we",     {31'b0, we_rf_o}, 32'd0);
        check("sw_retire", {31'b0, retire_o}, 32'd1);

        // Illegal outranks load-misaligned; flush lasts two cycles
        instr = op_inst(OPC_OP, 3'b000, 5'd5);
        send(instr, 32'h40, 32'h55, 32'h0, 32'h3001, 32'h0, F_LD | F_ILL);
        check_trap("prio", 32'h100);
        check("prio_flush1", {31'b0, flush_o}, 32'd1);
        check("prio_ready1", {31'b0, ready_o}, 32'd0);
        check("prio_state1", {31'b0, dbg_state_o}, {31'b0, ST_FLUSH});
        @(negedge clk_i);
        check("prio_flush2", {31'b0, flush_o}, 32'd1);
        check("prio_ready2", {31'b0, ready_o}, 32'd0);
        check("prio_redir2", {31'b0, redirect_o}, 32'd0);
        @(negedge clk_i);
        check("prio_flush3", {31'b0, flush_o}, 32'd0);
        check("prio_ready3", {31'b0, ready_o}, 32'd1);
        read_csr("prio_mcause", CSR_MCAUSE, 32'd2);
        read_csr("prio_mepc",   CSR_MEPC,   32'h40);
        read_csr("prio_mtval",  CSR_MTVAL,  instr);

        // Inst-misaligned outranks everything
        send(op_inst(OPC_JAL, 3'b000, 5'd1), 32'h44, 32'h302, 32'h0, 32'h0, 32'h0, F_INST | F_ST | F_ILL);
        check_trap("imis", 32'h100);
        read_csr("imis_mcause", CSR_MCAUSE, 32'd0);
        read_csr("imis_mtval",  CSR_MTVAL,  32'h302);
        read_csr("imis_mepc",   CSR_MEPC,   32'h44);

        // Store-misaligned
        send(op_inst(OPC_STORE, 3'b010, 5'd0), 32'h48, 32'h0, 32'h0, 32'h2001, 32'h0, F_ST);
        check_trap("smis", 32'h100);
        read_csr("smis_mcause", CSR_MCAUSE, 32'd6);
        read_csr("smis_mtval",  CSR_MTVAL,  32'h2001);

        // CSRRW mtvec, then back-to-back read sees the new value
        send(csr_inst(CSR_MTVEC, 5'd1, F3_CSRRW, 5'd9), 32'h50, 32'h0, 32'h0, 32'h0, 32'h203, NO_EXC);
        check("mtvec_old", rf_wd_o, 32'h100);
        check("mtvec_we",  {31'b0, we_rf_o}, 32'd1);
        read_csr("mtvec_new", CSR_MTVEC, 32'h200);

        // Set MIE, ECALL, then MRET restores it
        send(csr_inst(CSR_MSTATUS, 5'd8, F3_CSRRSI, 5'd10), 32'h54, 32'h0, 32'h0, 32'h0, 32'h8, NO_EXC);
        check("mstatus_old", rf_wd_o, 32'h0000_1800);
        send(INST_ECALL, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0, NO_EXC);
        check_trap("ecall", 32'h200);
        read_csr("ecall_mcause",  CSR_MCAUSE,  32'd11);
        read_csr("ecall_mtval",   CSR_MTVAL,   32'd0);
        read_csr("ecall_mstatus", CSR_MSTATUS, 32'h0000_1880);
        send(INST_MRET, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0, NO_EXC);
        check("mret_redirect", {31'b0, redirect_o}, 32'd1);
        check("mret_pc",       redirect_pc_o, 32'h80);
        check("mret_retire",   {31'b0, retire_o}, 32'd1);
        check("mret_exc",      {31'b0, is_exc_taken_o}, 32'd0);
        check("mret_flush",    {31'b0, flush_o}, 32'd1);
        read_csr("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

        // EBREAK
        send(INST_EBREAK, 32'h84, 32'h0, 32'h0, 32'h0, 32'h0, NO_EXC);
        check_trap("ebreak", 32'h200);
        read_csr("ebreak_mcause", CSR_MCAUSE, 32'd3);
        read_csr("ebreak_mtval",  CSR_MTVAL,  32'h84);

        // Read-only mhartid: pure read is fine, a write is illegal
        send(csr_inst(CSR_MHARTID, 5'd0, F3_CSRRS, 5'd11), 32'h88, 32'h0, 32'h0, 32'h0, 32'h0, NO_EXC);
        check("hart_we",     {31'b0, we_rf_o}, 32'd1);
        check("hart_wd",     rf_wd_o, 32'd0);
        check("hart_exc",    {31'b0, is_exc_taken_o}, 32'd0);
        send(csr_inst(CSR_MHARTID, 5'd1, F3_CSRRW, 5'd12), 32'h8C, 32'h0, 32'h0, 32'h0, 32'h5, NO_EXC);
        check_trap("hart_wr", 32'h200);
        read_csr("hart_wr_mcause", CSR_MCAUSE, 32'd2);

        // Unknown CSR address
        instr = csr_inst(12'h7C0, 5'd0, F3_CSRRS, 5'd13);
        send(instr, 32'h90, 32'h0, 32'h0, 32'h0, 32'h0, NO_EXC);
        check_trap("unk", 32'h200);
        read_csr("unk_mcause", CSR_MCAUSE, 32'd2);
        read_csr("unk_mtval",  CSR_MTVAL,  instr);

        // Reset during the second FLUSH cycle
        send(INST_ECALL, 32'h94, 32'h0, 32'h0, 32'h0, 32'h0, NO_EXC);
        check("mid_flush1", {31'b0, flush_o}, 32'd1);
        @(negedge clk_i);
        check("mid_flush2", {31'b0, flush_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("mid_rst_flush", {31'b0, flush_o}, 32'd0);
        check("mid_rst_ready", {31'b0, ready_o}, 32'd1);
        check("mid_rst_redir", {31'b0, redirect_o}, 32'd0);
        check("mid_rst_exc",   {31'b0, is_exc_taken_o}, 32'd0);
        check("mid_rst_state", {31'b0, dbg_state_o}, {31'b0, ST_RUN});
        read_csr("mid_rst_mtvec",   CSR_MTVEC,   32'h100);
        read_csr("mid_rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
        read_csr("mid_rst_mcause",  CSR_MCAUSE,  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
